emif_write: RTL and testbench

- MCU-read responder on the EMIF bus: FPGA-side data toward the MCU.
- Internal logic posts status words (encoder position, status flags) into an 8-word register bank.
- When the MCU performs a read strobe, the block snapshots the addressed word, waits a fixed setup interval, drives it onto the data bus, then releases the bus with a turnaround gap.
- Sits beside the EMIF capture path in the control-board top level.

---
 rtl/emif_pkg.sv | 16 +
 rtl/emif_sync2.sv | 29 ++
 rtl/emif_write.sv | 169 ++++++++++++++++
 tb/tb_emif_write.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_pkg.sv
// Shared definitions for the EMIF MCU-read responder.
// FSM encoding and register-bank geometry.
package emif_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam int REG_NUM     = 8;
  localparam int ADDR_W      = 13;
  localparam int VERSION_IDX = 7;

endpackage

// File: rtl/emif_sync2.sv
// Two-flop synchronizer with a registered edge flop.
// q is the synchronized level, rise pulses one cycle on its 0->1 edge.
module emif_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic q_d;

  // Synchronizer chain plus edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      s1  <= d;
      q   <= s1;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;

endmodule

// File: rtl/emif_write.sv
// EMIF read responder: snapshot, setup wait, drive, turnaround.
// Optional DRIVE timeout enabled by defining EMIF_WR_TIMEOUT_EN.
module emif_write
  import emif_pkg::*;
#(
  parameter int          WAIT_CYC    = 3,
  parameter int          TURN_CYC    = 2,
  parameter logic [15:0] VERSION     = 16'h0100,
  parameter int          TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] emif_addr,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [15:0]       wr_data,
  output logic [15:0]       data_out,
  output logic              data_oe,
  output logic              read_ack,
  output logic              addr_err
`ifdef EMIF_WR_TIMEOUT_EN
  ,
  output logic              rd_timeout
`endif
);

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYC);
  localparam logic [3:0] TURN_L = 4'(TURN_CYC - 1);
  localparam logic [2:0] VER_I  = 3'(VERSION_IDX);

  logic        read_en_s;
  logic        rise;
  logic [15:0] bank [0:REG_NUM-2];
  logic [15:0] rd_word;
  logic        in_range;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] snap, snap_n;
  logic        ack_n, err_n;

`ifdef EMIF_WR_TIMEOUT_EN
  localparam logic [9:0] TO_L = 10'(TIMEOUT_CYC - 1);
  logic [9:0]  tcnt, tcnt_n;
  logic        to_n;
`endif

  emif_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (read_en),
    .q     (read_en_s),
    .rise  (rise)
  );

  // Internal status bank; index 7 is the read-only version word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM - 1; i++)
        bank[i] <= '0;
    end else if (wr_en && wr_addr != VER_I) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // Addressed word lookup
  always_comb begin
    rd_word  = '0;
    in_range = emif_addr < ADDR_W'(REG_NUM);
    if (emif_addr[2:0] == VER_I)
      rd_word = VERSION;
    else
      rd_word = bank[emif_addr[2:0]];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    ack_n   = 1'b0;
    err_n   = 1'b0;
`ifdef EMIF_WR_TIMEOUT_EN
    tcnt_n  = tcnt;
    to_n    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (rise) begin
          state_n = S_WAIT;
          cnt_n   = '0;
          if (in_range) begin
            snap_n = rd_word;
          end else begin
            snap_n = '0;
            err_n  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!read_en_s) begin
          state_n = S_TURN;
          cnt_n   = '0;
        end else if (cnt == WAIT_C) begin
          state_n = S_DRIVE;
          ack_n   = 1'b1;
`ifdef EMIF_WR_TIMEOUT_EN
          tcnt_n  = '0;
`endif
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_DRIVE: begin
        if (!read_en_s) begin
          state_n = S_TURN;
          cnt_n   = '0;
        end
`ifdef EMIF_WR_TIMEOUT_EN
        else if (tcnt == TO_L) begin
          state_n = S_TURN;
          cnt_n   = '0;
          to_n    = 1'b1;
        end else begin
          tcnt_n = tcnt + 10'd1;
        end
`endif
      end
      S_TURN: begin
        if (cnt == TURN_L)
          state_n = S_IDLE;
        else
          cnt_n = cnt + 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered pad outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      snap     <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      read_ack <= 1'b0;
      addr_err <= 1'b0;
`ifdef EMIF_WR_TIMEOUT_EN
      tcnt       <= '0;
      rd_timeout <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      snap     <= snap_n;
      data_oe  <= (state_n == S_DRIVE);
      data_out <= (state_n == S_DRIVE) ? snap_n : '0;
      read_ack <= ack_n;
      addr_err <= err_n;
`ifdef EMIF_WR_TIMEOUT_EN
      tcnt       <= tcnt_n;
      rd_timeout <= to_n;
`endif
    end
  end

endmodule

// File: tb/tb_emif_write.sv
// Testbench for emif_write: directed reads plus randomized reads
// against a transaction-level model of the bank and bus timing.
module tb_emif_write;
  import emif_pkg::*;

  localparam int          WAIT_CYC    = 3;
  localparam int          TURN_CYC    = 2;
  localparam logic [15:0] VERSION     = 16'h0100;
  localparam int          TIMEOUT_CYC = 1000;
  localparam int          LAT  = 2 + 1 + WAIT_CYC + 1;
  localparam int          SNAP = 2 + 1;
  localparam int          DROP = 2 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_en = 1'b0;
  logic [12:0] emif_addr = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] data_out;
  logic        data_oe;
  logic        read_ack;
  logic        addr_err;
`ifdef EMIF_WR_TIMEOUT_EN
  logic        rd_timeout;
`endif

  emif_write #(
    .WAIT_CYC    (WAIT_CYC),
    .TURN_CYC    (TURN_CYC),
    .VERSION     (VERSION),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_en   (read_en),
    .emif_addr (emif_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .read_ack  (read_ack),
    .addr_err  (addr_err)
`ifdef EMIF_WR_TIMEOUT_EN
    ,
    .rd_timeout (rd_timeout)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mbank [8];
  logic [12:0] cur_addr;
  logic [15:0] exp_data;
  logic [15:0] drv_val;
  int c, ack_n, oe_n, err_n, to_n, first_oe, bad_data;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) mbank[i] = '0;
    mbank[7] = VERSION;
  endtask

  task automatic clear_obs();
    c = 0; ack_n = 0; oe_n = 0; err_n = 0; to_n = 0;
    first_oe = 0; bad_data = 0; drv_val = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    c++;
    if (c == SNAP)
      exp_data = (cur_addr < 13'd8) ? mbank[cur_addr[2:0]] : 16'h0;
    if (wr_en && wr_addr != 3'd7) mbank[wr_addr] = wr_data;
    #1;
    ack_n += int'(read_ack);
    oe_n  += int'(data_oe);
    err_n += int'(addr_err);
`ifdef EMIF_WR_TIMEOUT_EN
    to_n  += int'(rd_timeout);
`endif
    if (data_oe) begin
      if (first_oe == 0) first_oe = c;
      drv_val = data_out;
      if (data_out !== exp_data) bad_data++;
    end else if (data_out !== 16'h0) begin
      bad_data++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
  endtask

  task automatic do_read(input logic [12:0] addr, input int h,
                         input bit rnd, input int wi,
                         input logic [2:0] wa, input logic [15:0] wd);
    bit drive;
    int len;
    clear_obs();
    cur_addr  = addr;
    emif_addr = addr;
    read_en   = 1'b1;
    for (int i = 1; i <= h + 12; i++) begin
      cycle();
      if (i == h) read_en = 1'b0;
      if (i == wi) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = 16'($urandom);
      end
    end
    len   = h + DROP - LAT;
    drive = len > 0;
    check("oe_cycles", oe_n, drive ? len : 0);
    check("ack_count", ack_n, drive ? 1 : 0);
    check("first_oe", first_oe, drive ? LAT : 0);
    check("addr_err", err_n, (addr >= 13'd8) ? 1 : 0);
    check("data_bus", bad_data, 0);
    check("oe_idle", data_oe, 0);
  endtask

  initial begin
    model_reset();
    exp_data = '0;
    cur_addr = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 16'h0);
    check("rst_data_oe", data_oe, 0);
    check("rst_read_ack", read_ack, 0);
    check("rst_addr_err", addr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    write(3'd3, 16'h1234);
    do_read(13'd3, 20, 0, 0, 3'd0, 16'h0);
    check("basic_value", drv_val, 16'h1234);

    do_read(13'd7, 10, 0, 0, 3'd0, 16'h0);
    check("version_value", drv_val, 16'h0100);

    write(3'd7, 16'hDEAD);
    do_read(13'd7, 10, 0, 0, 3'd0, 16'h0);
    check("version_ro", drv_val, 16'h0100);

    do_read(13'h0100, 10, 0, 0, 3'd0, 16'h0);
    check("range_value", drv_val, 16'h0000);

    write(3'd2, 16'hAAAA);
    do_read(13'd2, 15, 0, 9, 3'd2, 16'h5555);
    check("coh_hold", drv_val, 16'hAAAA);
    do_read(13'd2, 10, 0, 0, 3'd0, 16'h0);
    check("coh_new", drv_val, 16'h5555);

    write(3'd4, 16'h0F0F);
    do_read(13'd4, 10, 0, SNAP - 1, 3'd4, 16'hF0F0);
    check("same_cyc_pre", drv_val, 16'h0F0F);

    do_read(13'd5, 3, 0, 0, 3'd0, 16'h0);
    do_read(13'd6, 4, 0, 0, 3'd0, 16'h0);
    do_read(13'd6, 5, 0, 0, 3'd0, 16'h0);

    clear_obs();
    cur_addr = 13'd3; emif_addr = 13'd3;
    read_en = 1'b1;
    for (int i = 1; i <= 10; i++) cycle();
    read_en = 1'b0;
    cycle();
    read_en = 1'b1;
    for (int i = 1; i <= 10; i++) cycle();
    read_en = 1'b0;
    for (int i = 1; i <= 12; i++) cycle();
    check("b2b_acks", ack_n, 1);
    check("b2b_oe", oe_n, 10 + DROP - LAT);

    clear_obs();
    cur_addr = 13'd3; emif_addr = 13'd3;
    read_en = 1'b1;
    for (int i = 1; i <= 9; i++) cycle();
    check("pre_rst_oe", data_oe, 1);
    rst_n = 1'b0;
    read_en = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_oe", data_oe, 0);
    check("mid_rst_data", data_out, 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    do_read(13'd3, 8, 0, 0, 3'd0, 16'h0);
    check("post_rst_bank", drv_val, 16'h0000);

`ifdef EMIF_WR_TIMEOUT_EN
    clear_obs();
    cur_addr = 13'd7; emif_addr = 13'd7;
    read_en = 1'b1;
    for (int i = 1; i <= 1200; i++) cycle();
    read_en = 1'b0;
    for (int i = 1; i <= 12; i++) cycle();
    check("to_oe_len", oe_n, TIMEOUT_CYC);
    check("to_pulses", to_n, 1);
    check("to_acks", ack_n, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [12:0] a;
      if ($urandom_range(0, 3) == 0)
        a = 13'($urandom_range(8, 8191));
      else
        a = 13'($urandom_range(0, 7));
      do_read(a, $urandom_range(3, 14), 1, 0, 3'd0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
